// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage to DE2 SRAM path: FSM encodings, bus widths,
// and the byte-address to SRAM word-address mapping.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int WORD_ADDR_W = SRAM_ADDR_W - 1;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    // Bits above the SRAM range are dropped, so accesses wrap modulo 128K words.
    function automatic logic [WORD_ADDR_W-1:0] word_addr(input logic [31:0] byte_addr,
                                                         input logic [31:0] base);
        return WORD_ADDR_W'((byte_addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that stretches each half-word phase to WAIT_CYCLES+1 cycles
// and flags the final (and next-to-final) cycle of the phase.
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic clock,
    input  logic rst,
    input  logic load,
    output logic phase_last,
    output logic phase_penult
);

    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(WAIT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign phase_last   = (cnt_q == '0);
    assign phase_penult = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM accesses (low half,
// then high half) and stalls the pipeline through ready until the word completes.
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   rdEn,
    input  logic                   wrEn,
    input  logic [31:0]            address,
    input  logic [31:0]            writeData,
    output logic [31:0]            readData,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N
);

    mem_state_e             state_q, state_d;
    logic [WORD_ADDR_W-1:0] word_q, word_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   is_write_q, is_write_d;
    logic [SRAM_DATA_W-1:0] lo_q, lo_d;
    logic [31:0]            read_data_q, read_data_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [SRAM_DATA_W-1:0] dq_out_q, dq_out_d;
    logic                   dq_oe_q, dq_oe_d;
    logic                   we_n_q, we_n_d;
    logic                   oe_n_q, oe_n_d;

    logic load, phase_last, phase_penult, next_last, in_phase;

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clock        (clock),
        .rst          (rst),
        .load         (load),
        .phase_last   (phase_last),
        .phase_penult (phase_penult)
    );

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        is_write_d  = is_write_q;
        lo_d        = lo_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        load        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rdEn | wrEn) begin
                    state_d    = ST_LO;
                    word_d     = word_addr(address, BASE_ADDR);
                    wdata_d    = writeData;
                    is_write_d = wrEn;
                    load       = 1'b1;
                end
            end
            ST_LO: begin
                if (phase_last) begin
                    if (!is_write_q) lo_d = SRAM_DQ;
                    state_d = ST_HI;
                    load    = 1'b1;
                end
            end
            ST_HI: begin
                if (phase_last) begin
                    if (!is_write_q) read_data_d = {SRAM_DQ, lo_q};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Pin values are computed for the cycle being entered so they leave flops.
        next_last = load ? (WAIT_CYCLES == 0) : phase_penult;
        in_phase  = (state_d == ST_LO) || (state_d == ST_HI);
        if (in_phase) sram_addr_d = {word_d, (state_d == ST_HI)};
        dq_out_d = (state_d == ST_HI) ? wdata_d[31:16] : wdata_d[15:0];
        dq_oe_d  = in_phase & is_write_d;
        we_n_d   = ~(in_phase & is_write_d & (~next_last | (WAIT_CYCLES == 0)));
        oe_n_d   = ~(in_phase & ~is_write_d);
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            is_write_q  <= 1'b0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
        end
    end

    always_ff @(posedge clock) begin
        word_q   <= word_d;
        wdata_q  <= wdata_d;
        lo_q     <= lo_d;
        dq_out_q <= dq_out_d;
    end

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : {SRAM_DATA_W{1'bz}};
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign readData  = read_data_q;
    assign ready     = (state_q == ST_DONE) | ~(rdEn | wrEn);

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: async 256K x 16 SRAM model on the pins and a word-level
// reference memory that predicts load data, SRAM contents, addresses and latency.
module tb_sram_controller;

    localparam logic [31:0] BASE = 32'd1024;

    logic        clock = 1'b0;
    logic        rst, rdEn, wrEn;
    logic [31:0] address, writeData;
    wire  [31:0] readData;
    wire         ready;
    wire  [17:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    wire         SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N;

    sram_controller dut (
        .clock     (clock),
        .rst       (rst),
        .rdEn      (rdEn),
        .wrEn      (wrEn),
        .address   (address),
        .writeData (writeData),
        .readData  (readData),
        .ready     (ready),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_DQ   (SRAM_DQ),
        .SRAM_UB_N (SRAM_UB_N),
        .SRAM_LB_N (SRAM_LB_N),
        .SRAM_CE_N (SRAM_CE_N),
        .SRAM_WE_N (SRAM_WE_N),
        .SRAM_OE_N (SRAM_OE_N)
    );

    always #5 clock = ~clock;

    // Async SRAM: drives the bus while OE_N is low, latches data on the WE_N rising edge.
    logic [15:0] sram_mem [0:262143];
    assign SRAM_DQ = (!SRAM_OE_N) ? sram_mem[SRAM_ADDR] : 16'hzzzz;
    always @(posedge SRAM_WE_N) begin
        if (rst && !SRAM_CE_N) sram_mem[SRAM_ADDR] <= SRAM_DQ;
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rd = 32'h0;
    logic [31:0] ref_mem [int];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int word_index(input logic [31:0] a);
        return int'(((a - BASE) >> 2) % 32'd131072);
    endfunction

    function automatic logic [31:0] ref_read(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    // Called #1 after a rising edge; that cycle is cycle 0 of the request.
    task automatic run_access(input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] d);
        int lat  = 0;
        bit seen = 0;
        int w    = word_index(a);
        rdEn = rd; wrEn = wr; address = a; writeData = d;
        while (!seen && lat < 20) begin
            @(negedge clock);
            if (wr) check("oe_n_during_write", 32'(SRAM_OE_N), 32'd1);
            else    check("we_n_during_read", 32'(SRAM_WE_N), 32'd1);
            if (lat == 1) check("addr_lo_half", 32'(SRAM_ADDR), 32'(2 * w));
            if (lat == 3) check("addr_hi_half", 32'(SRAM_ADDR), 32'(2 * w + 1));
            if (ready) seen = 1;
            else begin
                @(posedge clock); #1;
                lat++;
            end
        end
        check("ready_latency", seen ? 32'(lat) : 32'd999, 32'd5);
        if (wr) begin
            ref_mem[w] = d;
            check("sram_lo_word", 32'(sram_mem[2 * w]), 32'(d[15:0]));
            check("sram_hi_word", 32'(sram_mem[2 * w + 1]), 32'(d[31:16]));
        end else begin
            exp_rd = ref_read(w);
        end
        check("read_data", readData, exp_rd);
        @(posedge clock); #1;
        rdEn = 1'b0; wrEn = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        int          kind;
        for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
        rst = 1'b0; rdEn = 1'b1; wrEn = 1'b0; address = BASE; writeData = 32'h0;

        // Reset held with a pending load.
        repeat (2) @(posedge clock);
        #1;
        check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        check("rst_oe_n", 32'(SRAM_OE_N), 32'd1);
        check("rst_read_data", readData, 32'h0);
        check("rst_sram_addr", 32'(SRAM_ADDR), 32'h0);
        check("rst_ce_ub_lb", {29'h0, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 32'h0);
        rst = 1'b1;
        check("ready_after_release", 32'(ready), 32'd0);
        run_access(1, 0, BASE, 32'h0);

        // Directed store/load pairs.
        run_access(0, 1, BASE + 8, 32'hDEADBEEF);
        run_access(1, 0, BASE + 8, 32'h0);
        check("load_deadbeef", readData, 32'hDEADBEEF);
        run_access(0, 1, BASE, 32'h12345678);
        run_access(1, 0, BASE, 32'h0);
        check("back_to_back_load", readData, 32'h12345678);
        run_access(1, 1, BASE + 4, 32'hA5A5_5A5A);
        check("both_en_keeps_read_data", readData, 32'h12345678);
        check("both_en_lo", 32'(sram_mem[2]), 32'h5A5A);
        check("both_en_hi", 32'(sram_mem[3]), 32'hA5A5);

        // Randomized traffic, including wrapped addresses and idle gaps.
        repeat (40) begin
            kind = int'($urandom_range(0, 2));
            a = BASE + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) a = a + ($urandom_range(1, 3) << 19);
            d = $urandom;
            run_access(kind != 1, kind != 0, a, d);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
            end
        end

        // Reset asserted during the high half of a store.
        rdEn = 1'b0; wrEn = 1'b1; address = BASE + 32'h400; writeData = $urandom;
        repeat (3) begin
            @(posedge clock); #1;
        end
        check("mid_store_hi_addr", 32'(SRAM_ADDR), 32'(2 * word_index(BASE + 32'h400) + 1));
        rst = 1'b0;
        @(posedge clock); #1;
        check("mid_rst_we_n", 32'(SRAM_WE_N), 32'd1);
        check("mid_rst_oe_n", 32'(SRAM_OE_N), 32'd1);
        rst = 1'b1; wrEn = 1'b0;
        run_access(1, 0, BASE + (32'd1 << 19), 32'h0);
        check("wrap_read_word0", readData, ref_read(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
